execute_alu: RTL and testbench
==============================

Name: execute_alu

Overview:
- Execute-stage datapath that directly consumes the 4-bit alu_op produced by decode's ALU control.
- Performs single-cycle integer ops with a registered result.
- Owns the HI/LO architectural registers and a 32-iteration signed restoring divider for DIV.
- Asserts stall back to the pipeline when an instruction needs HI/LO (DIV, MFHI, MFLO) while a divide is in flight.

Parameters:
- WIDTH, 32, datapath width; the divider iteration count equals WIDTH.

Ports:
- clock  in  1  pipeline clock
- reset_n  in  1  asynchronous, active-low reset
- valid_in  in  1  an instruction is presented this cycle
- alu_op  in  4  operation code (ALU_* constants)
- operand_a  in  WIDTH  rs value
- operand_b  in  WIDTH  rt value or already-extended immediate
- shamt  in  5  shift amount for SLL/SRA
- slt_unsigned  in  1  ALU_slt compares unsigned (SLTIU)
- hilo_sel  in  1  for ALU_rs_pass: 1 = HI (MFHI), 0 = LO (MFLO)
- stall  out  1  instruction not accepted this cycle; hold inputs
- result  out  WIDTH  registered result
- result_valid  out  1  result holds an accepted non-DIV op's value
- div_busy  out  1  divider FSM not IDLE
- div_zero  out  1  one-cycle pulse when a DIV by zero completes
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, reset_n=0): result=0, result_valid=0, hi=0, lo=0, div_busy=0, div_zero=0, FSM=IDLE. Reset mid-divide abandons it; HI/LO stay 0.
- Acceptance: accepted = valid_in & !stall.
- stall is combinational: valid_in & div_busy & (alu_op is ALU_div or ALU_rs_pass). Other ops proceed while a divide runs.
- Single-cycle ops: result registered at the edge after acceptance; result_valid=1 that cycle, else 0. All arithmetic mod 2^WIDTH, no overflow trap.
  - ALU_add: a+b.
  - ALU_sub: a-b.
  - ALU_AND: a&b.
  - ALU_OR: a|b.
  - ALU_sll: b<<shamt.
  - ALU_sra: b>>>shamt (arithmetic).
  - ALU_slli: b<<16.
  - ALU_slt: {0,(a<b)}, signed unless slt_unsigned.
  - ALU_rs_pass: hilo_sel ? hi : lo.
  - op 0 or ALU_undef: result=0, result_valid=1.
- DIV FSM states: IDLE, DIVIDE, FIXUP.
  - IDLE: accepted ALU_div latches |a|, |b| and both signs; iteration counter := WIDTH-1; go to DIVIDE. result_valid stays 0 for DIV.
  - DIVIDE: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). Counter decrements; when it reaches 0, go to FIXUP.
  - FIXUP: negate quotient if signs differ; remainder takes dividend's sign. Write lo=quotient, hi=remainder; go to IDLE.
- Latency: DIV accepted at edge N; hi/lo update at edge N+WIDTH+1 (33 for WIDTH=32). div_busy is 1 from edge N to edge N+WIDTH+1. An MFHI/MFLO stalled behind it is accepted the cycle div_busy falls.
- Divide by zero: runs full latency; lo=all-ones, hi=operand_a; div_zero pulses with the hi/lo write.
- Overflow (-2^(WIDTH-1) / -1): lo=0x80000000, hi=0.
- DIV while busy stalls; there is no back-to-back queueing.

Decomposition:
- mips.h holds the ALU_* opcode constants (shared with decode's ALU control) and WIDTH.
- Sub-module div_unit: FSM, counter, operand/remainder/quotient registers. Interface: start, dividend, divisor, busy, done, quotient, remainder, by_zero.
- execute_alu keeps the single-cycle ops, the HI/LO registers and the stall logic.

Test Plan:
- Reset mid-divide: DIV 100/7, drop reset_n at cycle 10 -> hi=lo=0, div_busy=0 immediately; a subsequent MFLO is accepted without stall and returns 0.
- Single-cycle ops: ADD 0x7FFFFFFF+1 -> 0x80000000; SRA 0x80000000 by 4 -> 0xF8000000; SLTI -1<1 -> 1; SLTIU 0xFFFFFFFF<1 -> 0; LUI b=0x1234 -> 0x12340000. Each has result_valid=1 one cycle after acceptance.
- DIV timing: DIV -7/2 at edge N -> lo=0xFFFFFFFD, hi=0xFFFFFFFF at edge N+33; div_busy high for exactly 33 cycles.
- Hazard: DIV 100/7 then MFHI next cycle -> stall high 32 cycles; MFHI accepted when div_busy falls; result=2. An ADD issued during the divide is not stalled.
- Divide by zero: DIV 5/0 -> lo=0xFFFFFFFF, hi=5, div_zero pulses one cycle at completion.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.

Source files
------------

// File: rtl/execute_alu_pkg.sv
// Shared ALU opcode constants, datapath width and divider state encoding for the
// execute stage. Decode's ALU control drives alu_op with these same codes.
package execute_alu_pkg;

    localparam int ALU_WIDTH = 32;

    // 4-bit operation codes carried from decode into execute.
    localparam logic [3:0] ALU_nop     = 4'd0;
    localparam logic [3:0] ALU_add     = 4'd1;
    localparam logic [3:0] ALU_sub     = 4'd2;
    localparam logic [3:0] ALU_AND     = 4'd3;
    localparam logic [3:0] ALU_OR      = 4'd4;
    localparam logic [3:0] ALU_sll     = 4'd5;
    localparam logic [3:0] ALU_sra     = 4'd6;
    localparam logic [3:0] ALU_slli    = 4'd7;
    localparam logic [3:0] ALU_slt     = 4'd8;
    localparam logic [3:0] ALU_rs_pass = 4'd9;
    localparam logic [3:0] ALU_div     = 4'd10;
    localparam logic [3:0] ALU_undef   = 4'd15;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_DIVIDE,
        DIV_FIXUP
    } div_state_t;

    // Ops that touch HI/LO and therefore must wait for an in-flight divide.
    function automatic logic is_hilo_op(input logic [3:0] op);
        return (op == ALU_div) || (op == ALU_rs_pass);
    endfunction

endpackage

// File: rtl/execute_alu_div_unit.sv
// Signed restoring divider: magnitudes are divided one quotient bit per cycle,
// then signs are restored in a single fix-up cycle.
module execute_alu_div_unit
    import execute_alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             by_zero
);

    localparam int CW = $clog2(WIDTH);

    div_state_t       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] quo;        // holds |dividend| and shifts quotient bits in
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;        // |divisor|
    logic [WIDTH-1:0] dvd_raw;    // original dividend, returned as remainder on /0
    logic             neg_q;
    logic             neg_r;
    logic             zero;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // One restoring step: shift the next dividend bit into the remainder and trial-subtract.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rem_next  = '0;
        q_bit     = 1'b0;
        rem_shift = {rem, quo[WIDTH-1]};
        diff      = rem_shift - {1'b0, dvs};
        if (diff[WIDTH]) begin
            rem_next = rem_shift[WIDTH-1:0];
            q_bit    = 1'b0;
        end else begin
            rem_next = diff[WIDTH-1:0];
            q_bit    = 1'b1;
        end
    end

    // Divider FSM with its operand, remainder and iteration-count registers.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state is written with non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            state   <= DIV_IDLE;
            count   <= '0;
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
            dvd_raw <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            zero    <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        quo     <= abs_val(dividend);
                        dvs     <= abs_val(divisor);
                        rem     <= '0;
                        dvd_raw <= dividend;
                        neg_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r   <= dividend[WIDTH-1];
                        zero    <= (divisor == '0);
                        count   <= CW'(WIDTH - 1);
                        state   <= DIV_DIVIDE;
                    end
                end
                DIV_DIVIDE: begin
                    rem   <= rem_next;
                    quo   <= {quo[WIDTH-2:0], q_bit};
                    count <= count - 1'b1;
                    if (count == '0) begin
                        state <= DIV_FIXUP;
                    end
                end
                DIV_FIXUP: begin
                    state <= DIV_IDLE;
                end
                default: begin
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

    // Sign fix-up is combinational and only consumed while done is high.
    assign busy      = (state != DIV_IDLE);
    assign done      = (state == DIV_FIXUP);
    assign by_zero   = done & zero;
    assign quotient  = zero  ? '1 : (neg_q ? -quo : quo);
    assign remainder = zero  ? dvd_raw : (neg_r ? -rem : rem);

endmodule

// File: rtl/execute_alu.sv
// Execute-stage ALU: single-cycle integer ops with a registered result, the HI/LO
// registers fed by a multi-cycle divider, and the HI/LO hazard stall.
module execute_alu
    import execute_alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             valid_in,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [4:0]       shamt,
    input  logic             slt_unsigned,
    input  logic             hilo_sel,
    output logic             stall,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             div_busy,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic             accepted;
    logic             div_start;
    logic             div_done;
    logic             div_by_zero;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;
    logic             lt;
    logic [WIDTH-1:0] alu_result;

    // Only HI/LO consumers wait on the divider; everything else flows past it.
    assign stall     = valid_in & div_busy & is_hilo_op(alu_op);
    assign accepted  = valid_in & ~stall;
    assign div_start = accepted & (alu_op == ALU_div);

    assign lt = slt_unsigned ? (operand_a < operand_b)
                             : ($signed(operand_a) < $signed(operand_b));

    // Single-cycle operation select; unknown codes produce zero.
    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_add:     alu_result = operand_a + operand_b;
            ALU_sub:     alu_result = operand_a - operand_b;
            ALU_AND:     alu_result = operand_a & operand_b;
            ALU_OR:      alu_result = operand_a | operand_b;
            ALU_sll:     alu_result = operand_b << shamt;
            ALU_sra:     alu_result = $signed(operand_b) >>> shamt;
            ALU_slli:    alu_result = operand_b << 16;
            ALU_slt:     alu_result = {{(WIDTH-1){1'b0}}, lt};
            ALU_rs_pass: alu_result = hilo_sel ? hi : lo;
            ALU_nop,
            ALU_undef:   alu_result = '0;
            default:     alu_result = '0;
        endcase
    end

    // Result register: loads on every accepted non-DIV op and holds otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result       <= '0;
            result_valid <= 1'b0;
        end else if (accepted && (alu_op != ALU_div)) begin
            result       <= alu_result;
            result_valid <= 1'b1;
        end else begin
            result_valid <= 1'b0;
        end
    end

    // HI/LO are written only in the divider's fix-up cycle; div_zero pulses with that write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            div_zero <= div_by_zero;
            if (div_done) begin
                hi <= div_rem;
                lo <= div_quo;
            end
        end
    end

    execute_alu_div_unit #(
        .WIDTH (WIDTH)
    ) u_div (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (div_start),
        .dividend  (operand_a),
        .divisor   (operand_b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem),
        .by_zero   (div_by_zero)
    );

endmodule

// File: tb/tb_execute_alu.sv
// Self-checking bench for execute_alu: a directed vector table, hand-written
// divider/hazard/reset sequences, and randomized ops against a behavioural model.
module tb_execute_alu;
    import execute_alu_pkg::*;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         valid_in;
    logic [3:0]   alu_op;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic [4:0]   shamt;
    logic         slt_unsigned;
    logic         hilo_sel;
    logic         stall;
    logic [W-1:0] result;
    logic         result_valid;
    logic         div_busy;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int vectors     = 0;
    int miscompares = 0;

    // Model of the architectural HI/LO registers.
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    always #5 clock = ~clock;

    execute_alu #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .valid_in     (valid_in),
        .alu_op       (alu_op),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .shamt        (shamt),
        .slt_unsigned (slt_unsigned),
        .hilo_sel     (hilo_sel),
        .stall        (stall),
        .result       (result),
        .result_valid (result_valid),
        .div_busy     (div_busy),
        .div_zero     (div_zero),
        .hi           (hi),
        .lo           (lo)
    );

    typedef struct {
        string        name;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [4:0]   sh;
        logic         su;
        logic         hs;
        logic [W-1:0] exp;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference for single-cycle ops, written straight from the operation definitions.
    function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [4:0] sh,
                                             input logic su, input logic hs);
        logic signed [W-1:0] sb;
        sb = b;
        case (op)
            ALU_add:     return a + b;
            ALU_sub:     return a - b;
            ALU_AND:     return a & b;
            ALU_OR:      return a | b;
            ALU_sll:     return b << sh;
            ALU_sra:     return sb >>> sh;
            ALU_slli:    return b * 32'h0001_0000;
            ALU_slt:     return su ? W'(a < b) : W'($signed(a) < $signed(b));
            ALU_rs_pass: return hs ? m_hi : m_lo;
            default:     return '0;
        endcase
    endfunction

    // Reference divide using the language's truncating signed / and %.
    task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r);
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = '0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] sh, input logic su, input logic hs);
        @(negedge clock);
        valid_in     = 1'b1;
        alu_op       = op;
        operand_a    = a;
        operand_b    = b;
        shamt        = sh;
        slt_unsigned = su;
        hilo_sel     = hs;
    endtask

    task automatic single_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [4:0] sh, input logic su,
                             input logic hs, input logic [W-1:0] exp);
        drive(op, a, b, sh, su, hs);
        #1;
        check({name, "_stall"}, W'(stall), '0);
        @(posedge clock);
        #1;
        valid_in = 1'b0;
        check({name, "_result"}, result, exp);
        check({name, "_valid"}, W'(result_valid), W'(1));
    endtask

    // Issue a DIV while idle and follow it to completion.
    task automatic run_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           cycles;
        ref_div(a, b, q, r);
        drive(ALU_div, a, b, 5'd0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        valid_in = 1'b0;
        check({name, "_rvalid"}, W'(result_valid), '0);
        cycles = 0;
        while (div_busy && cycles < 100) begin
            cycles++;
            @(posedge clock);
            #1;
        end
        check({name, "_busy_cycles"}, W'(cycles), W'(W + 1));
        check({name, "_lo"}, lo, q);
        check({name, "_hi"}, hi, r);
        check({name, "_div_zero"}, W'(div_zero), W'(b == '0));
        m_hi = r;
        m_lo = q;
        @(posedge clock);
        #1;
        check({name, "_div_zero_end"}, W'(div_zero), '0);
    endtask

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [3:0] rops[11];
        logic [3:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [4:0] sh;
        logic su;
        logic hs;
        int stall_cnt;

        rops = '{ALU_nop, ALU_add, ALU_sub, ALU_AND, ALU_OR, ALU_sll, ALU_sra,
                 ALU_slli, ALU_slt, ALU_rs_pass, ALU_undef};

        tbl[0]  = '{"add_wrap",  ALU_add,     32'h7FFF_FFFF, 32'h1,         5'd0,  1'b0, 1'b0, 32'h8000_0000};
        tbl[1]  = '{"sra4",      ALU_sra,     32'h0,         32'h8000_0000, 5'd4,  1'b0, 1'b0, 32'hF800_0000};
        tbl[2]  = '{"slti",      ALU_slt,     32'hFFFF_FFFF, 32'h1,         5'd0,  1'b0, 1'b0, 32'h1};
        tbl[3]  = '{"sltiu",     ALU_slt,     32'hFFFF_FFFF, 32'h1,         5'd0,  1'b1, 1'b0, 32'h0};
        tbl[4]  = '{"lui",       ALU_slli,    32'h0,         32'h1234,      5'd0,  1'b0, 1'b0, 32'h1234_0000};
        tbl[5]  = '{"sub_neg",   ALU_sub,     32'h5,         32'h7,         5'd0,  1'b0, 1'b0, 32'hFFFF_FFFE};
        tbl[6]  = '{"and",       ALU_AND,     32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  1'b0, 1'b0, 32'hF000_F000};
        tbl[7]  = '{"or",        ALU_OR,      32'hF0F0_F0F0, 32'h0F0F_0000, 5'd0,  1'b0, 1'b0, 32'hFFFF_F0F0};
        tbl[8]  = '{"sll31",     ALU_sll,     32'h0,         32'h1,         5'd31, 1'b0, 1'b0, 32'h8000_0000};
        tbl[9]  = '{"op0",       ALU_nop,     32'h5,         32'h6,         5'd0,  1'b0, 1'b0, 32'h0};
        tbl[10] = '{"undef",     ALU_undef,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  1'b0, 1'b0, 32'h0};
        tbl[11] = '{"mfhi_rst",  ALU_rs_pass, 32'h1,         32'h2,         5'd0,  1'b0, 1'b1, 32'h0};

        valid_in     = 1'b0;
        alu_op       = ALU_nop;
        operand_a    = '0;
        operand_b    = '0;
        shamt        = '0;
        slt_unsigned = 1'b0;
        hilo_sel     = 1'b0;
        m_hi         = '0;
        m_lo         = '0;

        // Reset state.
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_result", result, '0);
        check("rst_rvalid", W'(result_valid), '0);
        check("rst_hi", hi, '0);
        check("rst_lo", lo, '0);
        check("rst_busy", W'(div_busy), '0);
        check("rst_div_zero", W'(div_zero), '0);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed single-cycle vectors.
        for (int i = 0; i < 12; i++) begin
            single_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh,
                      tbl[i].su, tbl[i].hs, tbl[i].exp);
        end
        @(posedge clock);
        #1;
        check("rvalid_idle", W'(result_valid), '0);

        // Divider latency, divide by zero and the overflow case.
        run_div("div_m7_2", 32'hFFFF_FFF9, 32'h2);
        check("div_m7_2_lo_const", lo, 32'hFFFF_FFFD);
        check("div_m7_2_hi_const", hi, 32'hFFFF_FFFF);
        run_div("div_by0", 32'h5, 32'h0);
        run_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF);

        // Hazard: ADD proceeds under the divide, MFHI stalls until busy falls.
        drive(ALU_div, 32'd100, 32'd7, 5'd0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        valid_in = 1'b0;
        m_hi = 32'd2;
        m_lo = 32'd14;
        single_op("add_in_div", ALU_add, 32'd3, 32'd4, 5'd0, 1'b0, 1'b0, 32'd7);
        drive(ALU_rs_pass, '0, '0, 5'd0, 1'b0, 1'b1);
        #1;
        stall_cnt = 0;
        while (stall && stall_cnt < 100) begin
            stall_cnt++;
            @(negedge clock);
            #1;
        end
        check("mfhi_stall_cycles", W'(stall_cnt), W'(32));
        check("mfhi_busy_low", W'(div_busy), '0);
        @(posedge clock);
        #1;
        valid_in = 1'b0;
        check("mfhi_result", result, 32'd2);
        check("mfhi_valid", W'(result_valid), W'(1));
        check("hazard_lo", lo, 32'd14);

        // Reset mid-divide abandons it and clears HI/LO.
        drive(ALU_div, 32'd100, 32'd7, 5'd0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        valid_in = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midrst_hi", hi, '0);
        check("midrst_lo", lo, '0);
        check("midrst_busy", W'(div_busy), '0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clock);
        reset_n = 1'b1;
        single_op("midrst_mflo", ALU_rs_pass, '0, '0, 5'd0, 1'b0, 1'b0, '0);

        // Randomized ops and divides against the model.
        for (int n = 0; n < 300; n++) begin
            a = rand_val();
            b = rand_val();
            if ($urandom_range(0, 14) == 0) begin
                run_div("rnd_div", a, b);
            end else begin
                op = rops[$urandom_range(0, 10)];
                sh = 5'($urandom_range(0, 31));
                su = 1'($urandom_range(0, 1));
                hs = 1'($urandom_range(0, 1));
                single_op("rnd_op", op, a, b, sh, su, hs, ref_alu(op, a, b, sh, su, hs));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
